// File: rtl/rv_exec_decode_unit.sv
// RV32I decode/execute slice: main control, ALU control, operand select, integer ALU, one output register.
// Optional macro EXEC_ILLEGAL_TRAP_EN adds the registered ILLEGAL_Q flag.
module rv_exec_decode_unit #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 10
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   CLEAR,
    input  logic                   IN_VALID,
    input  logic [31:0]            INST,
    input  logic [ADDR_SIZE+1:0]   PC,
    input  logic [DATA_SIZE-1:0]   RS1_DATA,
    input  logic [DATA_SIZE-1:0]   RS2_DATA,
    input  logic [DATA_SIZE-1:0]   IMM,
    output logic                   OUT_VALID,
    output logic                   BRANCH_Q,
    output logic                   REG_WRITE_Q,
    output logic                   MEM_READ_Q,
    output logic                   MEM_WRITE_Q,
    output logic [1:0]             MEM_TO_REG_Q,
    output logic [DATA_SIZE-1:0]   ALU_RESULT_Q,
    output logic                   ZERO_Q,
    output logic                   TAKEN_Q,
    output logic [4:0]             RD_Q,
    output logic [DATA_SIZE-1:0]   STORE_DATA_Q
`ifdef EXEC_ILLEGAL_TRAP_EN
    ,
    output logic                   ILLEGAL_Q
`endif
);

    localparam int PC_PAD = DATA_SIZE - ADDR_SIZE - 2;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic       branch;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic [1:0] mem_to_reg;
        logic [1:0] auipc_lui;
    } ctrl_t;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 alt;
    logic                 unlisted;
    logic                 illegal;
    ctrl_t                ctrl;
    alu_op_e              alu_op;
    logic [DATA_SIZE-1:0] op_a;
    logic [DATA_SIZE-1:0] op_b;
    logic [4:0]           shamt;
    logic [DATA_SIZE-1:0] alu_result;
    logic                 zero;
    logic                 br_cond;
    logic                 taken;
    logic                 unused_rs_fields;

    assign opcode = INST[6:0];
    assign funct3 = INST[14:12];
    assign alt    = INST[30];
    // Register-number fields are consumed by the register file upstream, not here.
    assign unused_rs_fields = ^INST[24:15];

    // NOTE: every output of a combinational block gets a default before the case, so no path can infer a latch.
    always_comb begin
        ctrl     = '0;
        unlisted = 1'b0;
        unique case (opcode)
            OP_R:     ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
            OP_I:     ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0};
            OP_LOAD:  ctrl = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0};
            OP_STORE: ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0};
            OP_BR:    ctrl = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
            OP_JAL,
            OP_JALR:  ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 2'd0};
            OP_LUI:   ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd2};
            OP_AUIPC: ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd1};
            default:  unlisted = 1'b1;
        endcase

        // Malformed R-types retire as control-less bubbles, trap flag or not.
        illegal = unlisted ||
                  ((opcode == OP_R) &&
                   (((INST[31:25] != 7'b0000000) && (INST[31:25] != 7'b0100000)) ||
                    (alt && (funct3 != 3'b000) && (funct3 != 3'b101))));
        if (illegal) begin
            ctrl = '0;
        end
    end

    always_comb begin
        alu_op = ALU_ADD;
        if ((opcode == OP_R) || (opcode == OP_I)) begin
            unique case (funct3)
                3'b000:  alu_op = ((opcode == OP_R) && alt) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end else if (opcode == OP_BR) begin
            unique case (funct3)
                3'b000, 3'b001: alu_op = ALU_SUB;
                3'b100, 3'b101: alu_op = ALU_SLT;
                3'b110, 3'b111: alu_op = ALU_SLTU;
                default:        alu_op = ALU_ADD;
            endcase
        end
    end

    always_comb begin
        unique case (ctrl.auipc_lui)
            2'd0:    op_a = RS1_DATA;
            2'd1:    op_a = {{PC_PAD{1'b0}}, PC};
            default: op_a = '0;
        endcase
        op_b  = ctrl.alu_src ? IMM : RS2_DATA;
        shamt = op_b[4:0];
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD:  alu_result = op_a + op_b;
            ALU_SUB:  alu_result = op_a - op_b;
            ALU_AND:  alu_result = op_a & op_b;
            ALU_OR:   alu_result = op_a | op_b;
            ALU_XOR:  alu_result = op_a ^ op_b;
            ALU_SLL:  alu_result = op_a << shamt;
            ALU_SRL:  alu_result = op_a >> shamt;
            ALU_SRA:  alu_result = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_result = {{(DATA_SIZE-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: alu_result = {{(DATA_SIZE-1){1'b0}}, (op_a < op_b)};
            default:  alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // SLT/SLTU leave 1 when rs1 < rs2, so "less than" branches take on a non-zero result.
    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:         br_cond = zero;
            3'b001:         br_cond = !zero;
            3'b100, 3'b110: br_cond = !zero;
            3'b101, 3'b111: br_cond = zero;
            default:        br_cond = 1'b0;
        endcase
    end

    assign taken = ctrl.branch && br_cond;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            OUT_VALID    <= 1'b0;
            BRANCH_Q     <= 1'b0;
            REG_WRITE_Q  <= 1'b0;
            MEM_READ_Q   <= 1'b0;
            MEM_WRITE_Q  <= 1'b0;
            MEM_TO_REG_Q <= 2'd0;
            ALU_RESULT_Q <= '0;
            ZERO_Q       <= 1'b0;
            TAKEN_Q      <= 1'b0;
            RD_Q         <= 5'd0;
            STORE_DATA_Q <= '0;
        end else if (CLEAR || !IN_VALID) begin
            OUT_VALID    <= 1'b0;
            BRANCH_Q     <= 1'b0;
            REG_WRITE_Q  <= 1'b0;
            MEM_READ_Q   <= 1'b0;
            MEM_WRITE_Q  <= 1'b0;
            MEM_TO_REG_Q <= 2'd0;
            ALU_RESULT_Q <= '0;
            ZERO_Q       <= 1'b0;
            TAKEN_Q      <= 1'b0;
            RD_Q         <= 5'd0;
            STORE_DATA_Q <= '0;
        end else begin
            OUT_VALID    <= 1'b1;
            BRANCH_Q     <= ctrl.branch;
            REG_WRITE_Q  <= ctrl.reg_write;
            MEM_READ_Q   <= ctrl.mem_read;
            MEM_WRITE_Q  <= ctrl.mem_write;
            MEM_TO_REG_Q <= ctrl.mem_to_reg;
            ALU_RESULT_Q <= alu_result;
            ZERO_Q       <= zero;
            TAKEN_Q      <= taken;
            RD_Q         <= INST[11:7];
            STORE_DATA_Q <= RS2_DATA;
        end
    end

`ifdef EXEC_ILLEGAL_TRAP_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ILLEGAL_Q <= 1'b0;
        end else begin
            ILLEGAL_Q <= IN_VALID && !CLEAR && illegal;
        end
    end
`endif

endmodule

// File: tb/tb_rv_exec_decode_unit.sv
// Self-checking bench for rv_exec_decode_unit: table of vectors through a scoreboard queue,
// plus hand sequences for CLEAR and asynchronous RESET.
module tb_rv_exec_decode_unit;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef struct {
        string      nm;
        bit         ctl_only;
        bit         valid;
        bit         branch;
        bit         reg_write;
        bit         mem_read;
        bit         mem_write;
        bit [1:0]   m2r;
        bit [31:0]  res;
        bit         zero;
        bit         taken;
        bit [4:0]   rd;
        bit [31:0]  store;
        bit         ill;
    } exp_t;

    typedef struct {
        bit         iv;
        bit [31:0]  inst;
        bit [11:0]  pc;
        bit [31:0]  rs1;
        bit [31:0]  rs2;
        bit [31:0]  imm;
        exp_t       e;
    } vec_t;

    logic        CLK;
    logic        RESET;
    logic        CLEAR;
    logic        IN_VALID;
    logic [31:0] INST;
    logic [11:0] PC;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic [31:0] IMM;
    logic        OUT_VALID;
    logic        BRANCH_Q;
    logic        REG_WRITE_Q;
    logic        MEM_READ_Q;
    logic        MEM_WRITE_Q;
    logic [1:0]  MEM_TO_REG_Q;
    logic [31:0] ALU_RESULT_Q;
    logic        ZERO_Q;
    logic        TAKEN_Q;
    logic [4:0]  RD_Q;
    logic [31:0] STORE_DATA_Q;
`ifdef EXEC_ILLEGAL_TRAP_EN
    logic        ILLEGAL_Q;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    vec_t vecs[$];

    rv_exec_decode_unit #(.DATA_SIZE(32), .ADDR_SIZE(10)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CLEAR        (CLEAR),
        .IN_VALID     (IN_VALID),
        .INST         (INST),
        .PC           (PC),
        .RS1_DATA     (RS1_DATA),
        .RS2_DATA     (RS2_DATA),
        .IMM          (IMM),
        .OUT_VALID    (OUT_VALID),
        .BRANCH_Q     (BRANCH_Q),
        .REG_WRITE_Q  (REG_WRITE_Q),
        .MEM_READ_Q   (MEM_READ_Q),
        .MEM_WRITE_Q  (MEM_WRITE_Q),
        .MEM_TO_REG_Q (MEM_TO_REG_Q),
        .ALU_RESULT_Q (ALU_RESULT_Q),
        .ZERO_Q       (ZERO_Q),
        .TAKEN_Q      (TAKEN_Q),
        .RD_Q         (RD_Q),
        .STORE_DATA_Q (STORE_DATA_Q)
`ifdef EXEC_ILLEGAL_TRAP_EN
        ,
        .ILLEGAL_Q    (ILLEGAL_Q)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic bit [31:0] enc(bit [6:0] f7, bit [2:0] f3, bit [4:0] rd, bit [6:0] op);
        return {f7, 10'b0, f3, rd, op};
    endfunction

    function automatic exp_t ex(string nm, bit co, bit v, bit br, bit rw, bit mr, bit mw,
                                bit [1:0] m2r, bit [31:0] res, bit z, bit tk,
                                bit [4:0] rd, bit [31:0] st, bit ill);
        exp_t e;
        e.nm = nm;  e.ctl_only = co; e.valid = v;  e.branch = br; e.reg_write = rw;
        e.mem_read = mr; e.mem_write = mw; e.m2r = m2r; e.res = res; e.zero = z;
        e.taken = tk; e.rd = rd; e.store = st; e.ill = ill;
        return e;
    endfunction

    function automatic vec_t mkv(bit iv, bit [31:0] inst, bit [11:0] pc, bit [31:0] rs1,
                                 bit [31:0] rs2, bit [31:0] imm, exp_t e);
        vec_t v;
        v.iv = iv; v.inst = inst; v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.e = e;
        return v;
    endfunction

    task automatic compare_out(input exp_t e);
        check({e.nm, ".valid"},     {31'b0, OUT_VALID},   {31'b0, e.valid});
        check({e.nm, ".branch"},    {31'b0, BRANCH_Q},    {31'b0, e.branch});
        check({e.nm, ".reg_write"}, {31'b0, REG_WRITE_Q}, {31'b0, e.reg_write});
        check({e.nm, ".mem_read"},  {31'b0, MEM_READ_Q},  {31'b0, e.mem_read});
        check({e.nm, ".mem_write"}, {31'b0, MEM_WRITE_Q}, {31'b0, e.mem_write});
        check({e.nm, ".mem_to_reg"}, {30'b0, MEM_TO_REG_Q}, {30'b0, e.m2r});
        check({e.nm, ".taken"},     {31'b0, TAKEN_Q},     {31'b0, e.taken});
        if (!e.ctl_only) begin
            check({e.nm, ".result"}, ALU_RESULT_Q, e.res);
            check({e.nm, ".zero"},   {31'b0, ZERO_Q}, {31'b0, e.zero});
            check({e.nm, ".rd"},     {27'b0, RD_Q},   {27'b0, e.rd});
            check({e.nm, ".store"},  STORE_DATA_Q,    e.store);
        end
`ifdef EXEC_ILLEGAL_TRAP_EN
        check({e.nm, ".illegal"}, {31'b0, ILLEGAL_Q}, {31'b0, e.ill});
`endif
    endtask

    // Drive on the falling edge, retire through the scoreboard one rising edge later.
    task automatic step(input vec_t v, input bit clr);
        exp_t got;
        @(negedge CLK);
        IN_VALID = v.iv;
        CLEAR    = clr;
        INST     = v.inst;
        PC       = v.pc;
        RS1_DATA = v.rs1;
        RS2_DATA = v.rs2;
        IMM      = v.imm;
        sb.push_back(v.e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: queue empty at output, expected one entry");
        end else begin
            got = sb.pop_front();
            compare_out(got);
        end
    endtask

    exp_t bubble;
    vec_t v_add;

    initial begin
        RESET = 1'b1; CLEAR = 1'b0; IN_VALID = 1'b0;
        INST = 32'h0; PC = 12'h0; RS1_DATA = 32'h0; RS2_DATA = 32'h0; IMM = 32'h0;
        #2;
        bubble = ex("reset", 1'b0, 0, 0, 0, 0, 0, 2'd0, 32'h0, 0, 0, 5'd0, 32'h0, 0);
        compare_out(bubble);
        @(negedge CLK);
        RESET = 1'b0;

        //                      iv  inst                              pc      rs1           rs2           imm
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd3,  OP_R),     12'h0,  32'd5,        32'd7,        32'h0,
            ex("add",   0, 1, 0, 1, 0, 0, 2'd0, 32'd12,       0, 0, 5'd3,  32'd7,        0)));
        vecs.push_back(mkv(1, enc(7'h20, 3'b000, 5'd4,  OP_R),     12'h0,  32'd9,        32'd9,        32'h0,
            ex("sub",   0, 1, 0, 1, 0, 0, 2'd0, 32'd0,        1, 0, 5'd4,  32'd9,        0)));
        vecs.push_back(mkv(1, enc(7'h20, 3'b101, 5'd5,  OP_I),     12'h0,  32'h80000000, 32'h11,       32'h404,
            ex("srai",  0, 1, 0, 1, 0, 0, 2'd0, 32'hF8000000, 0, 0, 5'd5,  32'h11,       0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b001, 5'd0,  OP_BR),    12'h0,  32'd3,        32'd3,        32'h0,
            ex("bne",   0, 1, 1, 0, 0, 0, 2'd0, 32'd0,        1, 0, 5'd0,  32'd3,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b100, 5'd0,  OP_BR),    12'h0,  32'hFFFFFFFF, 32'd1,        32'h0,
            ex("blt",   0, 1, 1, 0, 0, 0, 2'd0, 32'd1,        0, 1, 5'd0,  32'd1,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b111, 5'd0,  OP_BR),    12'h0,  32'hFFFFFFFF, 32'd1,        32'h0,
            ex("bgeu",  0, 1, 1, 0, 0, 0, 2'd0, 32'd0,        1, 1, 5'd0,  32'd1,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd0,  OP_BR),    12'h0,  32'd4,        32'd5,        32'h0,
            ex("beq",   0, 1, 1, 0, 0, 0, 2'd0, 32'hFFFFFFFF, 0, 0, 5'd0,  32'd5,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b010, 5'd6,  OP_LOAD),  12'h0,  32'h100,      32'h55,       32'h8,
            ex("lw",    0, 1, 0, 1, 1, 0, 2'd1, 32'h108,      0, 0, 5'd6,  32'h55,       0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b010, 5'd0,  OP_STORE), 12'h0,  32'h200,      32'hDEADBEEF, 32'h4,
            ex("sw",    0, 1, 0, 0, 0, 1, 2'd0, 32'h204,      0, 0, 5'd0,  32'hDEADBEEF, 0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd7,  OP_LUI),   12'h0,  32'hAAAA,     32'h0,        32'h12345000,
            ex("lui",   0, 1, 0, 1, 0, 0, 2'd0, 32'h12345000, 0, 0, 5'd7,  32'h0,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd8,  OP_AUIPC), 12'h040, 32'h999,     32'h0,        32'h1000,
            ex("auipc", 0, 1, 0, 1, 0, 0, 2'd0, 32'h1040,     0, 0, 5'd8,  32'h0,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd1,  OP_JAL),   12'h080, 32'h10,      32'h0,        32'h20,
            ex("jal",   0, 1, 0, 1, 0, 0, 2'd2, 32'h30,       0, 0, 5'd1,  32'h0,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd2,  OP_JALR),  12'h0,  32'h100,      32'h0,        32'h4,
            ex("jalr",  0, 1, 0, 1, 0, 0, 2'd2, 32'h104,      0, 0, 5'd2,  32'h0,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b001, 5'd9,  OP_R),     12'h0,  32'd1,        32'h23,       32'h0,
            ex("sll",   0, 1, 0, 1, 0, 0, 2'd0, 32'd8,        0, 0, 5'd9,  32'h23,       0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b101, 5'd10, OP_R),     12'h0,  32'h80000000, 32'h1F,       32'h0,
            ex("srl",   0, 1, 0, 1, 0, 0, 2'd0, 32'd1,        0, 0, 5'd10, 32'h1F,       0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd11, OP_R),     12'h0,  32'hFFFFFFFF, 32'd1,        32'h0,
            ex("addwrap", 0, 1, 0, 1, 0, 0, 2'd0, 32'd0,      1, 0, 5'd11, 32'd1,        0)));
        vecs.push_back(mkv(1, enc(7'h20, 3'b000, 5'd12, OP_I),     12'h0,  32'hA,        32'h0,        32'd5,
            ex("addi30", 0, 1, 0, 1, 0, 0, 2'd0, 32'hF,       0, 0, 5'd12, 32'h0,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b011, 5'd13, OP_R),     12'h0,  32'd1,        32'hFFFFFFFF, 32'h0,
            ex("sltu",  0, 1, 0, 1, 0, 0, 2'd0, 32'd1,        0, 0, 5'd13, 32'hFFFFFFFF, 0)));
        vecs.push_back(mkv(0, enc(7'h00, 3'b000, 5'd3,  OP_R),     12'h0,  32'd5,        32'd7,        32'h0,
            ex("novalid", 0, 0, 0, 0, 0, 0, 2'd0, 32'd0,      0, 0, 5'd0,  32'd0,        0)));
        vecs.push_back(mkv(1, enc(7'h00, 3'b000, 5'd2,  7'h7F),    12'h0,  32'd2,        32'd3,        32'h0,
            ex("op7f",  1, 1, 0, 0, 0, 0, 2'd0, 32'd0,        0, 0, 5'd0,  32'd0,        1)));
        vecs.push_back(mkv(1, enc(7'h01, 3'b000, 5'd3,  OP_R),     12'h0,  32'd2,        32'd3,        32'h0,
            ex("rf7bad", 1, 1, 0, 0, 0, 0, 2'd0, 32'd0,       0, 0, 5'd0,  32'd0,        1)));
        vecs.push_back(mkv(1, enc(7'h20, 3'b001, 5'd4,  OP_R),     12'h0,  32'd2,        32'd3,        32'h0,
            ex("raltbad", 1, 1, 0, 0, 0, 0, 2'd0, 32'd0,      0, 0, 5'd0,  32'd0,        1)));

        foreach (vecs[i]) step(vecs[i], 1'b0);

        // CLEAR turns a valid instruction into a bubble at the next edge.
        v_add = vecs[0];
        step(v_add, 1'b0);
        v_add.e = ex("clear", 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 0, 0, 5'd0, 32'd0, 0);
        step(v_add, 1'b1);

        // Async RESET mid-cycle with a valid instruction on the inputs.
        step(vecs[8], 1'b0);
        @(negedge CLK);
        IN_VALID = 1'b1; CLEAR = 1'b0;
        INST = enc(7'h00, 3'b000, 5'd14, OP_R);
        RS1_DATA = 32'd20; RS2_DATA = 32'd22; IMM = 32'h0;
        #2;
        RESET = 1'b1;
        #1;
        bubble.nm = "rst_async";
        compare_out(bubble);
        @(posedge CLK);
        #1;
        bubble.nm = "rst_held";
        compare_out(bubble);
        @(negedge CLK);
        RESET = 1'b0;
        step(mkv(1, enc(7'h00, 3'b000, 5'd14, OP_R), 12'h0, 32'd20, 32'd22, 32'h0,
             ex("post_rst", 0, 1, 0, 1, 0, 0, 2'd0, 32'd42, 0, 0, 5'd14, 32'd22, 0)), 1'b0);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_exec_decode_unit.md
Name: rv_exec_decode_unit

Overview:
- Single-stage decode/execute slice for the RV32I pipelined core: main control decode, ALU-operation decode, operand selection and the integer ALU, with one registered output stage.
- Sits between the ID/EX boundary and EX/MEM: takes an instruction plus operands; one cycle later presents control bits, ALU result, zero flag and branch decision.

Parameters:
- DATA_SIZE, 32, operand/result width.
- ADDR_SIZE, 10, word-address width; PC width is ADDR_SIZE+2.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- CLEAR  in  1  synchronous bubble insert.
- IN_VALID  in  1  inputs valid this cycle.
- INST  in  32  instruction word.
- PC  in  ADDR_SIZE+2  byte address of INST.
- RS1_DATA, RS2_DATA, IMM  in  DATA_SIZE each  register operands, sign-extended immediate.
- OUT_VALID  out  1  registered valid.
- BRANCH_Q, REG_WRITE_Q, MEM_READ_Q, MEM_WRITE_Q  out  1 each  registered control.
- MEM_TO_REG_Q  out  2  writeback select: 0 ALU, 1 memory, 2 PC+4.
- ALU_RESULT_Q  out  DATA_SIZE;  ZERO_Q  out  1  (result == 0).
- TAKEN_Q  out  1  branch resolved taken.
- RD_Q  out  5  INST[11:7];  STORE_DATA_Q  out  DATA_SIZE  RS2_DATA.

Behaviour:
- Main decode by INST[6:0] {BRANCH,REG_WRITE,MEM_READ,MEM_WRITE,ALU_SRC,MEM_TO_REG,AUIPC_LUI}: R 0110011 {0,1,0,0,0,0,0}; I-ALU 0010011 {0,1,0,0,1,0,0}; load 0000011 {0,1,1,0,1,1,0}; store 0100011 {0,0,0,1,1,0,0}; branch 1100011 {1,0,0,0,0,0,0}; JAL 1101111 and JALR 1100111 {0,1,0,0,1,2,0}; LUI 0110111 {0,1,0,0,1,0,2}; AUIPC 0010111 {0,1,0,0,1,0,1}; any other opcode all zero.
- Operand A: AUIPC_LUI 0 RS1_DATA, 1 zero-extended PC, 2 zero. Operand B: ALU_SRC ? IMM : RS2_DATA.
- ALU op codes: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9; codes 10-15 give result 0.
- ALU control: R-type funct3 000 ADD/SUB(INST[30]), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL/SRA(INST[30]), 110 OR, 111 AND. I-ALU same, but 000 always ADD; INST[30] used only for 101. Branch: funct3 000/001 SUB, 100/101 SLT, 110/111 SLTU. All other opcodes ADD.
- Shifts use B[4:0]; SLT signed, SLTU unsigned, result 1 or 0; add/sub wrap modulo 2^DATA_SIZE.
- TAKEN = BRANCH && (funct3 000: zero; 001: !zero; 100/110: !zero; 101/111: zero; 010/011: 0).
- Latency exactly 1 cycle; all outputs registered on rising CLK.
- RESET (async) or CLEAR or !IN_VALID at the edge: OUT_VALID and all control outputs including TAKEN_Q load 0; data outputs (ALU_RESULT_Q, RD_Q, STORE_DATA_Q) load 0; ZERO_Q 0. RESET has priority over CLEAR.
- Reset mid-operation discards the in-flight instruction; no state other than the output register.

Optional Feature:
- Macro EXEC_ILLEGAL_TRAP_EN. Defined: extra output ILLEGAL_Q (1 bit, registered, reset 0) set for a valid instruction with unlisted opcode or R-type with INST[31:25] not in {0000000, 0100000}, or R-type funct3 not in {000, 101} with INST[30]=1; control outputs still all zero. Undefined: port absent; such instructions decode as bubbles silently.

Test Plan:
- ADD x3 (R, funct3 000, INST[30]=0), RS1=5, RS2=7 -> next cycle ALU_RESULT_Q=12, REG_WRITE_Q=1, MEM_TO_REG_Q=0, ZERO_Q=0.
- SUB with INST[30]=1, RS1=RS2=9 -> ALU_RESULT_Q=0, ZERO_Q=1; SRAI RS1=0x80000000, IMM=4 -> 0xF8000000.
- BNE RS1=3, RS2=3 -> TAKEN_Q=0; BLT RS1=-1, RS2=1 -> TAKEN_Q=1; BGEU same operands -> TAKEN_Q=1.
- LW RS1=0x100, IMM=8 -> ALU_RESULT_Q=0x108, MEM_READ_Q=1, MEM_TO_REG_Q=1; SW -> MEM_WRITE_Q=1, STORE_DATA_Q=RS2_DATA.
- LUI IMM=0x12345000 -> 0x12345000; AUIPC PC=0x40, IMM=0x1000 -> 0x1040; JAL -> MEM_TO_REG_Q=2.
- Assert CLEAR, then async RESET mid-stream with IN_VALID=1 -> outputs zero immediately on RESET, OUT_VALID=0 after CLEAR edge; opcode 0x7F -> all controls 0 (ILLEGAL_Q=1 with EXEC_ILLEGAL_TRAP_EN).
